inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Parametrised instruction buffer between fetch and decode, replacing the single-entry fetch/decode register. Holds up to DEPTH fetched instructions with their PC, PC+1 and `distinct` tag, and accepts/issues them through valid/ready handshakes. Supports pipeline flush on branch redirect and presents the head entry pre-split into MIPS fields for the operator decoder.

## Interface
Parameters:
- INST_MEM_WIDTH, 2, width of `pc`/`pc1` (instruction memory address bits)
- DEPTH, 4, number of queue entries; power of two, >= 2
- CNT_W, $clog2(DEPTH+1), width of `count`

Ports:
- CLK  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept (not full)
- inst  in  32  fetched instruction word
- pc  in  INST_MEM_WIDTH  address of `inst`
- pc1  in  INST_MEM_WIDTH  sequential next address
- distinct  in  1  tag bit carried with the instruction
- flush  in  1  discard all queued entries (branch/jump redirect)
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head this cycle
- opcode  out  6  inst[31:26] of head
- rs, rt, rd, sa  out  5 each  inst[25:21], [20:16], [15:11], [10:6] of head
- funct  out  6  inst[5:0] of head
- immediate  out  16  inst[15:0] of head
- inst_index  out  26  inst[25:0] of head
- pc_next, pc1_next  out  INST_MEM_WIDTH  pc/pc1 of head
- distinct_next  out  1  distinct of head
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH entries of {inst, pc, pc1, distinct}; write pointer, read pointer (log2(DEPTH) bits, natural wrap), occupancy counter.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH). No pass-through when full: a full queue refuses a push even if a pop occurs the same cycle.
- out_valid = (count != 0).
- push only: write at wptr, wptr+1, count+1. pop only: rptr+1, count-1. Both: write and read, both pointers advance, count unchanged. Legal at any count 1..DEPTH-1; at count 0 only push happens (out_valid low), at count DEPTH only pop happens.
- flush: rptr, wptr, count <= 0 next edge; any push or pop in that same cycle is discarded (flush dominates). Entry contents need not be cleared.
- Field outputs are combinational slices of the head entry when out_valid=1. When empty, every field output, pc_next, pc1_next and distinct_next is driven 0 (inst 0 = sll $0,$0,0, a NOP bubble).
- Inputs held while in_ready=0 are not captured; fetch must hold them. Queue does not require in_valid to stay asserted.

## Timing
- Reset (reset_n low, asynchronous): pointers and count 0 immediately; therefore out_valid=0, in_ready=1, all field/pc outputs 0, count=0. Storage array need not be reset. Release is synchronous to CLK by the caller.
- Latency: entry pushed at edge N appears at head (out_valid=1, fields valid) after edge N; no same-cycle bypass from `inst` to outputs.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- count, in_ready, out_valid update only on edges (or async reset); field outputs change after a pop or after a push into an empty queue.
- Reset asserted mid-operation: queue empties immediately, regardless of flush/push/pop.
- Order is strict FIFO; wrap-around of pointers at DEPTH is transparent.

## Test plan
- Reset: drive reset_n=0 with in_valid=1, inst=32'h2008_0005 -> out_valid=0, in_ready=1, count=0, all fields 0; after release, no entry present.
- Single pass: push inst=32'h0232_4020 (add $8,$17,$18), pc=1, pc1=2, distinct=1 at edge N -> after N: out_valid=1, opcode=0, rs=17, rt=18, rd=8, sa=0, funct=6'h20, pc_next=1, pc1_next=2, distinct_next=1; pop -> out_valid=0, fields 0.
- Fill (DEPTH=4, out_ready=0): push 5 words -> count=4 after 4th push, in_ready=0, 5th word not stored; pop all -> words 1..4 in order.
- Wrap-around: sustained push+pop with count=2 for 10 cycles, inst = pc-tagged values -> outputs strictly in order, count stays 2, no gaps across pointer wrap.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 same cycle -> next edge count=0, out_valid=0, pushed word absent; next push appears alone at head.
- Full + pop: count=4, in_valid=1, out_ready=1 -> head consumed, push refused (in_ready=0), count=3.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - Fetch-to-decode instruction FIFO with flush and MIPS field split of the head entry
module inst_fetch_queue #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int DEPTH          = 4,
  parameter int CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               inst,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic                      distinct,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [5:0]                opcode,
  output logic [4:0]                rs,
  output logic [4:0]                rt,
  output logic [4:0]                rd,
  output logic [4:0]                sa,
  output logic [5:0]                funct,
  output logic [15:0]               immediate,
  output logic [25:0]               inst_index,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic                      distinct_next,
  output logic [CNT_W-1:0]          count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]               inst_mem [DEPTH];
  logic [INST_MEM_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_MEM_WIDTH-1:0] pc1_mem  [DEPTH];
  logic                      dist_mem [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             pop;
  logic [31:0]      head_inst;

  // A full queue refuses a push even when the head is popped the same cycle.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; only the pointers define occupancy.
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      inst_mem[wptr] <= inst;
      pc_mem[wptr]   <= pc;
      pc1_mem[wptr]  <= pc1;
      dist_mem[wptr] <= distinct;
    end
  end

  // An empty queue presents an all-zero word, i.e. a NOP bubble.
  assign head_inst     = out_valid ? inst_mem[rptr] : 32'd0;
  assign pc_next       = out_valid ? pc_mem[rptr]   : '0;
  assign pc1_next      = out_valid ? pc1_mem[rptr]  : '0;
  assign distinct_next = out_valid ? dist_mem[rptr] : 1'b0;

  assign opcode     = head_inst[31:26];
  assign rs         = head_inst[25:21];
  assign rt         = head_inst[20:16];
  assign rd         = head_inst[15:11];
  assign sa         = head_inst[10:6];
  assign funct      = head_inst[5:0];
  assign immediate  = head_inst[15:0];
  assign inst_index = head_inst[25:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - Directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int IMW   = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic [IMW-1:0]   pc;
  logic [IMW-1:0]   pc1;
  logic             distinct;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode;
  logic [4:0]       rs, rt, rd, sa;
  logic [5:0]       funct;
  logic [15:0]      immediate;
  logic [25:0]      inst_index;
  logic [IMW-1:0]   pc_next;
  logic [IMW-1:0]   pc1_next;
  logic             distinct_next;
  logic [CNT_W-1:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  inst_fetch_queue #(.INST_MEM_WIDTH(IMW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .pc1(pc1), .distinct(distinct), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .rs(rs),
    .rt(rt), .rd(rd), .sa(sa), .funct(funct), .immediate(immediate),
    .inst_index(inst_index), .pc_next(pc_next), .pc1_next(pc1_next),
    .distinct_next(distinct_next), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] head_word();
    return {opcode, inst_index};
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input int p, input logic r);
    in_valid  = v;
    inst      = w;
    pc        = IMW'(p);
    pc1       = IMW'(p + 1);
    distinct  = p[0];
    out_ready = r;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h2008_0005, 3, 1'b0);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_head",      head_word(),    32'd0);
    chk("rst_pc_next",   32'(pc_next),   32'd0);
    chk("rst_imm",       32'(immediate), 32'd0);
    reset_n = 1'b1;
    drive(1'b0, 32'd0, 0, 1'b0);
    step();
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Single pass of add $8,$17,$18.
    drive(1'b1, 32'h0232_4020, 1, 1'b0);
    distinct = 1'b1;
    step();
    drive(1'b0, 32'd0, 0, 1'b0);
    chk("sp_out_valid", 32'(out_valid), 32'd1);
    chk("sp_opcode",    32'(opcode),    32'd0);
    chk("sp_rs",        32'(rs),        32'd17);
    chk("sp_rt",        32'(rt),        32'd18);
    chk("sp_rd",        32'(rd),        32'd8);
    chk("sp_sa",        32'(sa),        32'd0);
    chk("sp_funct",     32'(funct),     32'h20);
    chk("sp_imm",       32'(immediate), 32'h4020);
    chk("sp_index",     32'(inst_index), 32'h0232_4020);
    chk("sp_pc_next",   32'(pc_next),   32'd1);
    chk("sp_pc1_next",  32'(pc1_next),  32'd2);
    chk("sp_distinct",  32'(distinct_next), 32'd1);
    chk("sp_count",     32'(count),     32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sp_pop_valid", 32'(out_valid), 32'd0);
    chk("sp_pop_funct", 32'(funct),     32'd0);
    chk("sp_pop_rs",    32'(rs),        32'd0);
    chk("sp_pop_pc",    32'(pc_next),   32'd0);
    chk("sp_pop_dist",  32'(distinct_next), 32'd0);

    // Fill with five words; the fifth must be refused.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'h1000_0000 + 32'(i), i, 1'b0);
      step();
      if (i == 4) begin
        chk("fill_count4",  32'(count),    32'd4);
        chk("fill_ready4",  32'(in_ready), 32'd0);
      end
    end
    chk("fill_count5", 32'(count), 32'd4);
    drive(1'b0, 32'd0, 0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_order", head_word(), 32'h1000_0000 + 32'(i));
      chk("fill_pc",    32'(pc_next), 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("fill_empty", 32'(out_valid), 32'd0);

    // Sustained push+pop at count 2 across pointer wrap.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h2000_0000 + 32'(k), k, 1'b0);
      step();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 32'h2000_0000 + 32'(c + 2), c + 2, 1'b1);
      chk("wrap_head",  head_word(),  32'h2000_0000 + 32'(c));
      chk("wrap_pc1",   32'(pc1_next), 32'(c + 1));
      chk("wrap_count", 32'(count),   32'd2);
      step();
    end
    chk("wrap_count_end", 32'(count), 32'd2);

    // Flush dominates a simultaneous push and pop.
    drive(1'b1, 32'h2000_00AA, 20, 1'b0);
    step();
    chk("fl_count3", 32'(count), 32'd3);
    flush = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 30, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 0, 1'b0);
    chk("fl_count",     32'(count),     32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready",  32'(in_ready),  32'd1);
    chk("fl_head_zero", head_word(),    32'd0);
    drive(1'b1, 32'h3000_0001, 7, 1'b0);
    step();
    drive(1'b0, 32'd0, 0, 1'b0);
    chk("fl_next_count", 32'(count),   32'd1);
    chk("fl_next_head",  head_word(),  32'h3000_0001);
    chk("fl_next_pc",    32'(pc_next), 32'd7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Full queue with simultaneous push and pop: only the pop happens.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h4000_0000 + 32'(i), 40 + i, 1'b0);
      step();
    end
    chk("fp_count4", 32'(count), 32'd4);
    drive(1'b1, 32'h4000_00FF, 99, 1'b1);
    chk("fp_in_ready", 32'(in_ready), 32'd0);
    step();
    drive(1'b0, 32'd0, 0, 1'b1);
    chk("fp_count3", 32'(count), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      chk("fp_order", head_word(), 32'h4000_0000 + 32'(i));
      step();
    end
    chk("fp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset mid-operation empties the queue without a clock edge.
    drive(1'b1, 32'h5000_0001, 5, 1'b0);
    step();
    drive(1'b1, 32'h5000_0002, 6, 1'b1);
    chk("ar_pre_count", 32'(count), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_count",     32'(count),     32'd0);
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_head",      head_word(),    32'd0);
    step();
    reset_n = 1'b1;
    drive(1'b0, 32'd0, 0, 1'b0);
    step();
    chk("ar_rel_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
